// File: rtl/axis_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : axis_mux_arb
// Brief    : Registered N:1 AXI-Stream mux with packet-aware fixed/RR arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module axis_mux_arb #(
    parameter int PORTS       = 4,
    parameter int PORT_BITS   = $clog2(PORTS),
    parameter int DATA_WIDTH  = 64,
    parameter int ARB_MODE    = 1,
    parameter int PACKET_MODE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        m_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic [PORT_BITS-1:0]        m_axis_tuser,
    output logic [PORTS-1:0]            sn_axis_tready,
    input  logic [PORTS*DATA_WIDTH-1:0] sn_axis_tdata,
    input  logic [PORTS-1:0]            sn_axis_tvalid,
    input  logic [PORTS-1:0]            sn_axis_tlast
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t                 r_state;
    logic [PORT_BITS-1:0]   r_grant;
    logic [PORT_BITS-1:0]   r_rr_ptr;
    logic [DATA_WIDTH-1:0]  r_tdata;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic [PORT_BITS-1:0]   r_tuser;

    logic                   w_lo_any;
    logic [PORT_BITS-1:0]   w_lo_sel;
    logic                   w_hi_any;
    logic [PORT_BITS-1:0]   w_hi_sel;
    logic [PORT_BITS-1:0]   w_arb_sel;
    logic [PORT_BITS-1:0]   w_sel;
    logic                   w_req;
    logic                   w_load_en;
    logic                   w_accept;
    logic                   w_end_txn;
    logic [PORT_BITS-1:0]   w_rr_next;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_sel_last;

    // Round-robin = lowest valid index at/above rr_ptr, else lowest overall.
    always_comb begin
        w_lo_any = 1'b0;
        w_lo_sel = '0;
        w_hi_any = 1'b0;
        w_hi_sel = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (sn_axis_tvalid[i]) begin
                w_lo_any = 1'b1;
                w_lo_sel = PORT_BITS'(i);
                if (i >= int'(r_rr_ptr)) begin
                    w_hi_any = 1'b1;
                    w_hi_sel = PORT_BITS'(i);
                end
            end
        end
    end

    assign w_arb_sel = ((ARB_MODE != 0) && w_hi_any) ? w_hi_sel : w_lo_sel;
    assign w_sel     = (r_state == S_LOCKED) ? r_grant : w_arb_sel;
    assign w_req     = (r_state == S_LOCKED) | w_lo_any;
    assign w_load_en = ~r_tvalid | m_axis_tready;

    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int g = 0; g < PORTS; g++) begin
            if (w_sel == PORT_BITS'(g)) begin
                w_sel_data = sn_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
                w_sel_last = sn_axis_tlast[g];
            end
        end
    end

    // Ready is held low for the whole reset, including before the first clock.
    generate
        for (genvar g = 0; g < PORTS; g++) begin : g_tready
            assign sn_axis_tready[g] = rst_n & w_load_en & w_req &
                                       (w_sel == PORT_BITS'(g));
        end
    endgenerate

    assign w_accept  = |(sn_axis_tready & sn_axis_tvalid);
    assign w_end_txn = (PACKET_MODE == 0) || w_sel_last;
    assign w_rr_next = (w_sel == PORT_BITS'(PORTS - 1)) ? '0 : w_sel + PORT_BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= '0;
        end else begin
            if (w_accept) begin
                r_tdata  <= w_sel_data;
                r_tlast  <= w_sel_last;
                r_tuser  <= w_sel;
                r_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end

            if (w_accept) begin
                if (w_end_txn) begin
                    r_rr_ptr <= w_rr_next;
                end
                case (r_state)
                    S_IDLE: begin
                        if ((PACKET_MODE != 0) && !w_sel_last) begin
                            r_state <= S_LOCKED;
                            r_grant <= w_sel;
                        end
                    end
                    S_LOCKED: begin
                        if (w_sel_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;

endmodule
`default_nettype wire

// File: tb/tb_axis_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_mux_arb
// Brief    : Self-checking bench for axis_mux_arb (RR instance + fixed-prio instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_mux_arb;
    localparam int P  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic [1:0]        m_tuser;
    logic [P-1:0]      s_tready;
    logic [P*DW-1:0]   s_tdata;
    logic [P-1:0]      s_tvalid;
    logic [P-1:0]      s_tlast;

    logic              fp_m_tready;
    logic [DW-1:0]     fp_m_tdata;
    logic              fp_m_tvalid;
    logic              fp_m_tlast;
    logic [1:0]        fp_m_tuser;
    logic [P-1:0]      fp_s_tready;
    logic [P*DW-1:0]   fp_s_tdata;
    logic [P-1:0]      fp_s_tvalid;
    logic [P-1:0]      fp_s_tlast;

    axis_mux_arb #(.PORTS(P), .DATA_WIDTH(DW), .ARB_MODE(1), .PACKET_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .sn_axis_tready(s_tready), .sn_axis_tdata(s_tdata), .sn_axis_tvalid(s_tvalid),
        .sn_axis_tlast(s_tlast)
    );

    axis_mux_arb #(.PORTS(P), .DATA_WIDTH(DW), .ARB_MODE(0), .PACKET_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .m_axis_tready(fp_m_tready), .m_axis_tdata(fp_m_tdata),
        .m_axis_tvalid(fp_m_tvalid), .m_axis_tlast(fp_m_tlast), .m_axis_tuser(fp_m_tuser),
        .sn_axis_tready(fp_s_tready), .sn_axis_tdata(fp_s_tdata), .sn_axis_tvalid(fp_s_tvalid),
        .sn_axis_tlast(fp_s_tlast)
    );

    typedef struct {
        logic [3:0] vld;
        logic [3:0] rdy;
        logic [1:0] usr;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  u;
        logic        l;
    } beat_t;

    vec_t   vecs[12];
    beat_t  exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;

    logic [16:0] pmem[P][16];
    int          phead[P];
    int          ptail[P];
    bit          en[P];

    bit          prev_stall;
    logic [19:0] prev_out;
    logic        last_mvalid;
    logic [3:0]  last_tready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_src();
        for (int p = 0; p < P; p++) begin
            phead[p] = 0;
            ptail[p] = 0;
            en[p]    = 1'b0;
        end
    endtask

    task automatic send(input int p, input logic [15:0] d, input logic l);
        pmem[p][ptail[p]] = {l, d};
        ptail[p]++;
    endtask

    task automatic expect_beat(input logic [15:0] d, input logic [1:0] u, input logic l);
        beat_t b;
        b.d = d; b.u = u; b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic drive();
        for (int p = 0; p < P; p++) begin
            if (en[p] && (phead[p] < ptail[p])) begin
                s_tvalid[p]          = 1'b1;
                s_tdata[p*DW +: DW]  = pmem[p][phead[p]][15:0];
                s_tlast[p]           = pmem[p][phead[p]][16];
            end else begin
                s_tvalid[p]          = 1'b0;
                s_tdata[p*DW +: DW]  = '0;
                s_tlast[p]           = 1'b0;
            end
        end
    endtask

    // One clock: drive sources, sample/score the output at negedge, retire accepted beats.
    task automatic cycle();
        logic [3:0] acc;
        beat_t      e;
        drive();
        @(negedge clk);
        if (prev_stall)
            check("stall_hold", {m_tvalid, m_tlast, m_tuser, m_tdata}, prev_out);
        if (m_tvalid && !m_tready)
            check("stall_tready", s_tready, 4'b0000);
        check("tready_onehot", ($countones(s_tready) <= 1), 1);
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", m_tdata, 64'hDEAD_0000);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", m_tdata, e.d);
                check("beat_port", m_tuser, e.u);
                check("beat_last", m_tlast, e.l);
            end
        end
        prev_stall  = m_tvalid && !m_tready;
        prev_out    = {m_tvalid, m_tlast, m_tuser, m_tdata};
        last_mvalid = m_tvalid;
        last_tready = s_tready;
        acc = s_tready & s_tvalid;
        @(posedge clk);
        #1;
        for (int p = 0; p < P; p++)
            if (acc[p]) phead[p]++;
    endtask

    task automatic run_until_empty(input string name, input int bound);
        int c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            cycle();
            c++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_src();
        drive();
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        check("rst_mvalid", m_tvalid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 4'b0001, 2'd0};
        vecs[1]  = '{4'b1111, 4'b0001, 2'd0};
        vecs[2]  = '{4'b1110, 4'b0010, 2'd1};
        vecs[3]  = '{4'b1100, 4'b0100, 2'd2};
        vecs[4]  = '{4'b1000, 4'b1000, 2'd3};
        vecs[5]  = '{4'b0000, 4'b0000, 2'd0};
        vecs[6]  = '{4'b1010, 4'b0010, 2'd1};
        vecs[7]  = '{4'b0101, 4'b0001, 2'd0};
        vecs[8]  = '{4'b0110, 4'b0010, 2'd1};
        vecs[9]  = '{4'b1001, 4'b0001, 2'd0};
        vecs[10] = '{4'b0100, 4'b0100, 2'd2};
        vecs[11] = '{4'b1111, 4'b0001, 2'd0};

        // Reset with every input valid.
        m_tready    = 1'b1;
        s_tvalid    = '1;
        s_tlast     = '1;
        s_tdata     = '0;
        fp_m_tready = 1'b1;
        fp_s_tvalid = '1;
        fp_s_tlast  = '1;
        for (int p = 0; p < P; p++)
            fp_s_tdata[p*DW +: DW] = 16'h00F0 + 16'(p);
        clear_src();
        prev_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mvalid", m_tvalid, 0);
        check("rst_tready", s_tready, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tuser", m_tuser, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_fp_tready", fp_s_tready, 0);
        s_tvalid    = '0;
        fp_s_tvalid = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Port 2 alone, 4-beat packet at full throughput.
        for (int k = 0; k < 4; k++) begin
            send(2, 16'h00A0 + 16'(k), (k == 3));
            expect_beat(16'h00A0 + 16'(k), 2'd2, (k == 3));
        end
        en[2] = 1'b1;
        repeat (5) cycle();
        check("throughput_drain", exp_q.size(), 0);
        cycle();
        cycle();

        // Packet lock: port 1 owns the output until its tlast.
        clear_src();
        for (int k = 0; k < 3; k++) begin
            send(1, 16'h00B0 + 16'(k), (k == 2));
            expect_beat(16'h00B0 + 16'(k), 2'd1, (k == 2));
        end
        send(0, 16'h00C0, 1'b1);
        expect_beat(16'h00C0, 2'd0, 1'b1);
        en[1] = 1'b1;
        cycle();
        en[0] = 1'b1;
        cycle();
        check("lock_hold", last_tready, 4'b0010);
        run_until_empty("lock_drain", 20);

        // Round-robin over single-beat packets from a fresh reset.
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < P; p++) begin
                send(p, 16'h0300 + 16'(p * 16 + k), 1'b1);
                expect_beat(16'h0300 + 16'(p * 16 + k), 2'(p), 1'b1);
            end
        for (int p = 0; p < P; p++) en[p] = 1'b1;
        repeat (13) cycle();
        check("rr_drain", exp_q.size(), 0);
        cycle();
        cycle();

        // Backpressure on a port-3 packet.
        begin
            bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
            int c = 0;
            clear_src();
            for (int k = 0; k < 4; k++) begin
                send(3, 16'h00D0 + 16'(k), (k == 3));
                expect_beat(16'h00D0 + 16'(k), 2'd3, (k == 3));
            end
            en[3] = 1'b1;
            while (exp_q.size() != 0 && c < 40) begin
                m_tready = pat[c % 4];
                cycle();
                c++;
            end
            check("bp_drain", exp_q.size(), 0);
            exp_q.delete();
            m_tready = 1'b1;
            cycle();
            cycle();
        end

        // Bubble inside a locked packet with another port waiting.
        clear_src();
        for (int k = 0; k < 4; k++) begin
            send(0, 16'h00E0 + 16'(k), (k == 3));
            expect_beat(16'h00E0 + 16'(k), 2'd0, (k == 3));
        end
        for (int k = 0; k < 2; k++) begin
            send(1, 16'h00F0 + 16'(k), (k == 1));
            expect_beat(16'h00F0 + 16'(k), 2'd1, (k == 1));
        end
        en[0] = 1'b1;
        cycle();
        cycle();
        en[0] = 1'b0;
        en[1] = 1'b1;
        cycle();
        check("bubble_first_valid", last_mvalid, 1);
        check("bubble_tready1", last_tready, 4'b0001);
        cycle();
        check("bubble_gap", last_mvalid, 0);
        check("bubble_tready2", last_tready, 4'b0001);
        en[0] = 1'b1;
        run_until_empty("bubble_drain", 20);

        // Reset mid-packet, then IDLE restarts at rr_ptr=0.
        clear_src();
        for (int k = 0; k < 4; k++)
            send(1, 16'h0060 + 16'(k), (k == 3));
        expect_beat(16'h0060, 2'd1, 1'b0);
        en[1] = 1'b1;
        cycle();
        cycle();
        check("midrst_pre", exp_q.size(), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_mvalid", m_tvalid, 0);
        check("midrst_tready", s_tready, 0);
        check("midrst_tdata", m_tdata, 0);
        check("midrst_tuser", m_tuser, 0);
        clear_src();
        drive();
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 16'h0070, 1'b1);
        send(3, 16'h0073, 1'b1);
        expect_beat(16'h0070, 2'd0, 1'b1);
        expect_beat(16'h0073, 2'd3, 1'b1);
        en[0] = 1'b1;
        en[3] = 1'b1;
        run_until_empty("midrst_drain", 20);

        // Fixed-priority instance: table of valid patterns.
        for (int i = 0; i < 12; i++) begin
            fp_s_tvalid = vecs[i].vld;
            @(negedge clk);
            check("fp_tready", fp_s_tready, vecs[i].rdy);
            @(posedge clk);
            #1;
            check("fp_mvalid", fp_m_tvalid, (vecs[i].vld != 4'b0000));
            if (vecs[i].vld != 4'b0000) begin
                check("fp_tuser", fp_m_tuser, vecs[i].usr);
                check("fp_tdata", fp_m_tdata, 16'h00F0 + 16'(vecs[i].usr));
            end
        end
        fp_s_tvalid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
